// File: rtl/acq_gate_sequencer.sv
// Single-pixel-imaging acquisition sequencer.
// Per pattern: pulse dmd_trig, wait SETTLE_CYC cycles, open the counting gate
// for max(cfg_window,1) cycles, then hold the per-channel counts on a
// valid/ready report until readout accepts them.
// Optional feature: define ACQ_COINC_EN to count gated cycles on which every
// channel fired (rd_coinc); when undefined rd_coinc is tied to 0.
module acq_gate_sequencer #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 32,
  parameter int PAT_W      = 16,
  parameter int SETTLE_CYC = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [WIN_W-1:0]        cfg_window,
  input  logic [PAT_W-1:0]        cfg_num_pat,
  input  logic [NUM_CH-1:0]       pulse_in,
  output logic                    dmd_trig,
  output logic                    gate,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [NUM_CH*CNT_W-1:0] rd_count,
  output logic [PAT_W-1:0]        rd_pat_idx,
  output logic [CNT_W-1:0]        rd_coinc,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_SETTLE, S_GATE, S_REPORT, S_NEXT, S_DONE
  } state_t;

  localparam bit               NO_SETTLE   = (SETTLE_CYC == 0);
  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYC - 1);

  state_t             state;
  logic [WIN_W-1:0]   win_len;
  logic [WIN_W-1:0]   tmr;
  logic [PAT_W-1:0]   num_pat;
  logic [PAT_W-1:0]   pat_idx;
  logic               stop_pend;
  logic [CNT_W-1:0]   cnt [NUM_CH];

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Sequencer FSM with registered strobes, gate, handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      win_len   <= '0;
      tmr       <= '0;
      num_pat   <= '0;
      pat_idx   <= '0;
      stop_pend <= 1'b0;
      dmd_trig  <= 1'b0;
      gate      <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      dmd_trig <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          // stop takes priority over a simultaneous start
          if (start && !stop) begin
            win_len   <= (cfg_window == '0) ? WIN_W'(1) : cfg_window;
            num_pat   <= cfg_num_pat;
            pat_idx   <= '0;
            stop_pend <= 1'b0;
            state     <= S_TRIG;
            dmd_trig  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_TRIG: begin
          tmr <= '0;
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (NO_SETTLE) begin
            state <= S_GATE;
            gate  <= 1'b1;
          end else begin
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (tmr == SETTLE_LAST) begin
            state <= S_GATE;
            gate  <= 1'b1;
            tmr   <= '0;
          end else begin
            tmr <= tmr + WIN_W'(1);
          end
        end
        S_GATE: begin
          if (stop) begin
            state <= S_IDLE;
            gate  <= 1'b0;
            busy  <= 1'b0;
          end else if (tmr == win_len - WIN_W'(1)) begin
            state    <= S_REPORT;
            gate     <= 1'b0;
            rd_valid <= 1'b1;
          end else begin
            tmr <= tmr + WIN_W'(1);
          end
        end
        S_REPORT: begin
          // an abort here still lets the pending report complete
          if (stop) stop_pend <= 1'b1;
          if (rd_ready) begin
            rd_valid <= 1'b0;
            if (stop || stop_pend) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            pat_idx <= pat_idx + PAT_W'(1);
            if (num_pat != '0 && pat_idx == num_pat - PAT_W'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_TRIG;
              dmd_trig <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          gate  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel photon counters: held clear between patterns, counting only while gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else if (state == S_IDLE || state == S_NEXT) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else if (state == S_GATE) begin
      for (int i = 0; i < NUM_CH; i++)
        if (pulse_in[i]) cnt[i] <= sat_inc(cnt[i]);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign rd_count[g*CNT_W +: CNT_W] = cnt[g];
  end

  assign rd_pat_idx = pat_idx;

`ifdef ACQ_COINC_EN
  logic [CNT_W-1:0] coinc;

  // Coincidence counter: gated cycles on which every channel fired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coinc <= '0;
    end else if (state == S_IDLE || state == S_NEXT) begin
      coinc <= '0;
    end else if (state == S_GATE && (&pulse_in)) begin
      coinc <= sat_inc(coinc);
    end
  end

  assign rd_coinc = coinc;
`else
  assign rd_coinc = '0;
`endif

endmodule

// File: tb/tb_acq_gate_sequencer.sv
// Bench for acq_gate_sequencer: directed vector table, hand-written abort and
// reset sequences, and randomized runs checked against a timeline model.
module tb_acq_gate_sequencer;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;
  localparam int WIN_W  = 32;
  localparam int PAT_W  = 16;
  localparam int SETTLE = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef ACQ_COINC_EN
  localparam bit COINC_ON = 1'b1;
`else
  localparam bit COINC_ON = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, rd_ready = 1'b0;
  logic [WIN_W-1:0]        cfg_window = '0;
  logic [PAT_W-1:0]        cfg_num_pat = '0;
  logic [NUM_CH-1:0]       pulse_in = '0;
  logic                    dmd_trig, gate, rd_valid, busy, done;
  logic [NUM_CH*CNT_W-1:0] rd_count;
  logic [PAT_W-1:0]        rd_pat_idx;
  logic [CNT_W-1:0]        rd_coinc;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  acq_gate_sequencer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .PAT_W(PAT_W), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_window(cfg_window), .cfg_num_pat(cfg_num_pat), .pulse_in(pulse_in),
    .dmd_trig(dmd_trig), .gate(gate), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_count(rd_count), .rd_pat_idx(rd_pat_idx), .rd_coinc(rd_coinc),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic int chan(input int i);
    return int'(rd_count[i*CNT_W +: CNT_W]);
  endfunction

  // Start a run; returns at the negedge where the first dmd_trig is visible.
  task automatic do_start(input int w, input int n);
    cfg_window  = WIN_W'(w);
    cfg_num_pat = PAT_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for gate (which=0) or rd_valid (which=1).
  task automatic wait_sig(input int which, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((which == 0 && gate === 1'b1) || (which == 1 && rd_valid === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Full run against the timeline model. Cycle n counts negedges after the
  // start edge: dmd_trig at t, gate over [t+1+SETTLE, t+SETTLE+W], report
  // from t+SETTLE+W+1 until ready, next trigger two cycles after acceptance.
  // pmode: 0 random, 1 ch0 every 2nd gated cycle, 2 ch0 held high,
  //        3 both at first gated cycle (+ one ignored in settle), 4 both held, 5 none.
  // rmode: <0 random ready, else ready asserted rmode cycles into each report.
  task automatic run_acq(input int w, input int npat, input int pmode, input int rmode,
                         output int c0, output int c1, output int co,
                         output int nrep, output int ntrig, output int ndone);
    int weff, n, t, gs, ge, endc, pat, bad;
    int ec [NUM_CH];
    int eco;
    logic [NUM_CH*CNT_W-1:0] snap;
    weff = (w == 0) ? 1 : w;
    c0 = -1; c1 = -1; co = -1; nrep = 0; ntrig = 0; ndone = 0; bad = 0;
    foreach (ec[i]) ec[i] = 0;
    eco = 0; snap = '0;
    do_start(w, npat);
    cfg_window  = $urandom;
    cfg_num_pat = PAT_W'($urandom);
    t = 0; n = 0; endc = -1; pat = 0;
    while (1) begin
      gs = t + 1 + SETTLE;
      ge = t + SETTLE + weff;
      if (dmd_trig !== (n == t)) bad++;
      if (gate !== (n >= gs && n <= ge)) bad++;
      if (rd_valid !== (n > ge)) bad++;
      if (done !== (n == endc)) bad++;
      if (busy !== (endc < 0 || n <= endc)) bad++;
      ntrig += int'(dmd_trig);
      ndone += int'(done);
      if (endc >= 0 && n == endc + 1) break;
      if (n > 6000) begin
        chk("run_timeout", 1, 0);
        break;
      end
      if (n == ge + 1) begin
        chk("rep_ch0", chan(0), sat(ec[0]));
        chk("rep_ch1", chan(1), sat(ec[1]));
        chk("rep_idx", rd_pat_idx, PAT_W'(pat));
        chk("rep_coinc", rd_coinc, COINC_ON ? sat(eco) : 0);
        if (nrep == 0) begin
          c0 = chan(0); c1 = chan(1); co = int'(rd_coinc);
        end
        nrep++;
        snap = rd_count;
      end
      if (n > ge && rd_count !== snap) bad++;
      case (pmode)
        0: pulse_in = NUM_CH'($urandom);
        1: begin pulse_in = '0; pulse_in[0] = (n >= gs && n <= ge && ((n - gs) % 2 == 0)); end
        2: begin pulse_in = '0; pulse_in[0] = 1'b1; end
        3: pulse_in = (n == gs || n == gs - 2) ? '1 : '0;
        4: pulse_in = '1;
        default: pulse_in = '0;
      endcase
      if (n >= gs && n <= ge) begin
        for (int i = 0; i < NUM_CH; i++) ec[i] += int'(pulse_in[i]);
        if (&pulse_in) eco++;
      end
      if (rmode < 0) rd_ready = ($urandom_range(0, 2) == 0);
      else           rd_ready = (n >= ge + 1 + rmode);
      if (rd_ready && n > ge) begin
        foreach (ec[i]) ec[i] = 0;
        eco = 0;
        pat++;
        if (npat != 0 && pat == npat) begin
          t = 1 << 28;
          endc = n + 2;
        end else begin
          t = n + 2;
        end
      end
      @(negedge clk);
      n++;
    end
    pulse_in = '0;
    rd_ready = 1'b0;
    chk("timeline", bad, 0);
  endtask

  typedef struct {
    int w; int npat; int pmode; int rmode;
    int e0; int e1; int eco; int erep; int etrig;
  } vec_t;

  initial begin
    vec_t vt [5];
    int c0, c1, co, nrep, ntrig, ndone, w, np;
    bit ok, seen;

    vt[0] = '{10, 3, 1, 0,  5, 0, 0, 3, 3};
    vt[1] = '{ 0, 1, 3, 0,  1, 1, 1, 1, 1};
    vt[2] = '{20, 1, 2, 1, 15, 0, 0, 1, 1};
    vt[3] = '{ 4, 1, 4, 2,  4, 4, 4, 1, 1};
    vt[4] = '{ 6, 2, 5, 50, 0, 0, 0, 2, 2};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gate", gate, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_trig", dmd_trig, 0);
    chk("rst_done", done, 0);
    chk("rst_count", rd_count, 0);
    chk("rst_idx", rd_pat_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset mid-GATE clears everything at once
    pulse_in = '1;
    do_start(50, 1);
    wait_sig(0, 100, ok);
    chk("rstg_wait_gate", ok, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstg_gate", gate, 0);
    chk("rstg_busy", busy, 0);
    chk("rstg_count", rd_count, 0);
    chk("rstg_coinc", rd_coinc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_in = '0;
    @(negedge clk);

    // directed vector table
    for (int k = 0; k < 5; k++) begin
      run_acq(vt[k].w, vt[k].npat, vt[k].pmode, vt[k].rmode, c0, c1, co, nrep, ntrig, ndone);
      chk($sformatf("vec%0d_ch0", k), c0, vt[k].e0);
      chk($sformatf("vec%0d_ch1", k), c1, vt[k].e1);
      chk($sformatf("vec%0d_coinc", k), co, COINC_ON ? vt[k].eco : 0);
      chk($sformatf("vec%0d_reports", k), nrep, vt[k].erep);
      chk($sformatf("vec%0d_trigs", k), ntrig, vt[k].etrig);
      chk($sformatf("vec%0d_done", k), ndone, 1);
    end

    // stop in GATE: idle next cycle, nothing reported
    pulse_in = '1;
    do_start(20, 1);
    wait_sig(0, 100, ok);
    chk("stopg_wait_gate", ok, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stopg_busy", busy, 0);
    chk("stopg_gate", gate, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rd_valid || done || dmd_trig) seen = 1'b1;
    end
    chk("stopg_quiet", seen, 0);
    pulse_in = '0;

    // stop in REPORT: handshake still completes, then idle with no done
    rd_ready = 1'b0;
    do_start(2, 3);
    wait_sig(1, 100, ok);
    chk("stopr_wait_valid", ok, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("stopr_valid_held", rd_valid, 1);
    chk("stopr_busy_held", busy, 1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("stopr_busy", busy, 0);
    chk("stopr_valid", rd_valid, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || dmd_trig || rd_valid) seen = 1'b1;
    end
    chk("stopr_quiet", seen, 0);

    // start and stop together in IDLE: stop wins
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_trig", dmd_trig, 0);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      w  = $urandom_range(0, 12);
      np = $urandom_range(1, 3);
      run_acq(w, np, 0, -1, c0, c1, co, nrep, ntrig, ndone);
      chk($sformatf("rnd%0d_reports", r), nrep, np);
      chk($sformatf("rnd%0d_trigs", r), ntrig, np);
      chk($sformatf("rnd%0d_done", r), ndone, 1);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
